// File: rtl/fifo_pkg.sv
// Shared types and helpers for the level-reporting FWFT FIFO.
package fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_t;

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; pointers and level define which words are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// First-word-fall-through FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             w,
    input  logic [WIDTH-1:0] din,
    input  logic             r,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level,
    input  logic [CNT_W-1:0] af_thr,
    input  logic [CNT_W-1:0] ae_thr,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    err_t             err_q, err_d;
    logic             acc_w, acc_r;

    assign full         = (level_q == FULL_LVL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= af_thr);
    assign almost_empty = (level_q <= ae_thr);
    assign level        = level_q;
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        acc_r   = r & ~empty;
        acc_w   = w & (~full | acc_r);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        err_d   = err_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            err_d   = '0;
        end else begin
            if (acc_w) wptr_d = wptr_q + AW'(1);
            if (acc_r) rptr_d = rptr_q + AW'(1);
            level_d = level_q + CNT_W'(acc_w) - CNT_W'(acc_r);
            if (w & full & ~r) err_d.overflow  = 1'b1;
            if (r & empty)     err_d.underflow = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            err_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // A flushed cycle must not disturb storage either.
    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (acc_w & ~clr),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (rptr_q),
        .rdata (dout)
    );

    level_consistent: assert property (@(posedge clk) disable iff (!rstn)
        (level_q <= FULL_LVL) &&
        (full ? (wptr_q == rptr_q) : (AW'(level_q) == AW'(wptr_q - rptr_q))));

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed bench for fifo_lvl (WIDTH=8, DEPTH=16): table vectors plus hand sequences.
module tb_fifo_lvl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clr;
    logic       w;
    logic [7:0] din;
    logic       r;
    logic [7:0] dout;
    logic       full, empty;
    logic [4:0] level;
    logic [4:0] af_thr, ae_thr;
    logic       almost_full, almost_empty;
    logic       overflow, underflow;

    int n_total = 0;
    int n_pass  = 0;

    fifo_lvl #(.WIDTH(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (clr),
        .w            (w),
        .din          (din),
        .r            (r),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .af_thr       (af_thr),
        .ae_thr       (ae_thr),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w, r, clr;
        logic [7:0] din;
        logic [4:0] af, ae;
        logic [4:0] e_lvl;
        logic       chk_d;
        logic [7:0] e_dout;
        logic       e_empty, e_full, e_afl, e_ael, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w = 1'b0; r = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; w = 1'b0; r = 1'b0; din = '0;
        af_thr = 5'd16; ae_thr = 5'd0;

        //               w     r     clr   din    af   ae    lvl  chk   dout   emp   full  afl   ael   ovf   unf
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd16, 5'd0,  5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h55, 5'd16, 5'd0,  5'd1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h66, 5'd16, 5'd0,  5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd16, 5'd0,  5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h77, 5'd16, 5'd0,  5'd1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd16, 5'd0,  5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  5'd16, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h88, 5'd0,  5'd16, 5'd1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1,  5'd0,  5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("rst level", level, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst overflow", overflow, 0);
        check("rst underflow", underflow, 0);
        rstn = 1'b1;

        // 1. Fill with 0x00..0x0F; head stays 0x00
        for (int i = 0; i < 16; i++) begin
            w = 1'b1; din = 8'(i);
            step();
            check($sformatf("fill level %0d", i), level, i + 1);
            check($sformatf("fill dout %0d", i), dout, 8'h00);
            check($sformatf("fill full %0d", i), full, (i == 15));
        end
        idle();

        // 2. Drain, expecting arrival order
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain dout %0d", i), dout, 8'(i));
            r = 1'b1;
            step();
            check($sformatf("drain level %0d", i), level, 15 - i);
        end
        idle();
        check("drain empty", empty, 1);
        check("drain overflow", overflow, 0);
        check("drain underflow", underflow, 0);

        // 3. Full with simultaneous push/pop, then a dropped push
        for (int i = 0; i < 16; i++) begin
            w = 1'b1; din = 8'(8'h10 + i);
            step();
        end
        w = 1'b1; r = 1'b1; din = 8'hAA;
        step();
        check("fullrw level", level, 16);
        check("fullrw overflow", overflow, 0);
        check("fullrw dout", dout, 8'h11);
        w = 1'b1; r = 1'b0; din = 8'hBB;
        step();
        check("ovf level", level, 16);
        check("ovf flag", overflow, 1);
        check("ovf dout", dout, 8'h11);
        idle();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullrw pop %0d", i), dout, (i == 15) ? 8'hAA : 8'(8'h11 + i));
            r = 1'b1;
            step();
        end
        idle();
        check("ovf sticky", overflow, 1);
        check("post-drain empty", empty, 1);
        clr = 1'b1;
        step();
        idle();
        check("clr overflow", overflow, 0);

        // 4. Underflow, empty push/pop, flush, threshold extremes
        for (int k = 0; k < 9; k++) begin
            w = vecs[k].w; r = vecs[k].r; clr = vecs[k].clr; din = vecs[k].din;
            af_thr = vecs[k].af; ae_thr = vecs[k].ae;
            step();
            check($sformatf("vec%0d level", k), level, vecs[k].e_lvl);
            if (vecs[k].chk_d) check($sformatf("vec%0d dout", k), dout, vecs[k].e_dout);
            check($sformatf("vec%0d empty", k), empty, vecs[k].e_empty);
            check($sformatf("vec%0d full", k), full, vecs[k].e_full);
            check($sformatf("vec%0d almost_full", k), almost_full, vecs[k].e_afl);
            check($sformatf("vec%0d almost_empty", k), almost_empty, vecs[k].e_ael);
            check($sformatf("vec%0d overflow", k), overflow, vecs[k].e_ovf);
            check($sformatf("vec%0d underflow", k), underflow, vecs[k].e_unf);
        end
        idle();

        // 5. Thresholds af=12, ae=3 over 12 pushes
        af_thr = 5'd12; ae_thr = 5'd3;
        for (int i = 0; i < 12; i++) begin
            w = 1'b1; din = 8'(8'h30 + i);
            step();
            check($sformatf("thr afl %0d", i + 1), almost_full, (i + 1 >= 12));
            check($sformatf("thr ael %0d", i + 1), almost_empty, (i + 1 <= 3));
        end
        idle();
        af_thr = 5'd13;
        #1;
        check("thr change afl", almost_full, 0);
        af_thr = 5'd12;
        #1;
        check("thr restore afl", almost_full, 1);
        clr = 1'b1;
        step();
        idle();
        check("thr clr level", level, 0);

        // 6. Async reset mid-burst at level 7
        for (int i = 0; i < 7; i++) begin
            w = 1'b1; din = 8'(8'h40 + i);
            step();
        end
        check("burst level", level, 7);
        #1;
        rstn = 1'b0;
        #1;
        check("async rst level", level, 0);
        check("async rst empty", empty, 1);
        idle();
        #3;
        rstn = 1'b1;
        w = 1'b1; din = 8'hC3;
        step();
        idle();
        check("post-rst level", level, 1);
        check("post-rst empty", empty, 0);
        check("post-rst dout", dout, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
